// File: rtl/tcp_tx_arbiter.sv
// TX scheduler for the single TCP/IP frame builder: control vs data arbitration.
// Define TCP_TX_ARB_ACK_PIGGYBACK_EN to let a DATA commit retire a pending ACK.
module tcp_tx_arbiter #(
  parameter int MAX_WAIT   = 16,
  parameter int TX_TIMEOUT = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_syn_ack,
  input  logic        req_fin_ack,
  input  logic        req_fin,
  input  logic        req_ack,
  input  logic        data_valid,
  input  logic [15:0] data_len,
  output logic        data_ready,
  input  logic        flush,
  output logic        tx_start,
  output logic [2:0]  tx_kind,
  output logic [15:0] tx_len,
  input  logic        tx_done,
  output logic        tx_abort,
  output logic [31:0] seq_link_add,
  output logic [31:0] seq_data_add,
  output logic        ip_id_link_new,
  output logic        ip_id_data_new,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT
  } state_t;

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_SYN  = 3'd1;
  localparam logic [2:0] K_FACK = 3'd2;
  localparam logic [2:0] K_FIN  = 3'd3;
  localparam logic [2:0] K_ACK  = 3'd4;
  localparam logic [2:0] K_DATA = 3'd5;

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int TW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

`ifdef TCP_TX_ARB_ACK_PIGGYBACK_EN
  localparam bit PIGGY = 1'b1;
`else
  localparam bit PIGGY = 1'b0;
`endif

  state_t        state_q, state_n;
  logic [2:0]    kind_q, kind_n;
  logic [15:0]   len_q, len_n;
  logic [3:0]    pend_q, pend_n;
  logic [SW-1:0] starve_q, starve_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic          rereq_q, rereq_n;
  logic          abort_q, abort_n;

  logic          data_req;
  logic          starved;
  logic [2:0]    win;
  logic [3:0]    req_vec;
  logic          own_req;
  logic          commit;
  logic          keep_own;
  logic [3:0]    clr;

  // pending bit order: [0] SYN_ACK, [1] FIN_ACK, [2] FIN, [3] ACK
  assign req_vec  = {req_ack, req_fin, req_fin_ack, req_syn_ack};
  assign data_req = data_valid && (data_len != 16'd0);
  assign starved  = (starve_q == STARVE_MAX);
  assign commit   = (state_q == S_COMMIT) && !flush;
  assign keep_own = rereq_q;

  always_comb begin
    win = K_NONE;
    if (pend_q[0])
      win = K_SYN;
    else if (pend_q[1])
      win = K_FACK;
    else if (pend_q[2])
      win = K_FIN;
    else if (data_req && starved)
      win = K_DATA;
    else if (pend_q[3])
      win = K_ACK;
    else if (data_req)
      win = K_DATA;
  end

  always_comb begin
    own_req = 1'b0;
    unique case (kind_q)
      K_SYN:   own_req = req_syn_ack;
      K_FACK:  own_req = req_fin_ack;
      K_FIN:   own_req = req_fin;
      K_ACK:   own_req = req_ack;
      default: own_req = 1'b0;
    endcase
  end

  // a re-request of the in-flight kind keeps its pending bit alive
  always_comb begin
    clr    = '0;
    clr[0] = commit && !keep_own && (kind_q == K_SYN);
    clr[1] = commit && !keep_own && (kind_q == K_FACK);
    clr[2] = commit && !keep_own && (kind_q == K_FIN);
    clr[3] = (commit && !keep_own && (kind_q == K_ACK))
           || (commit && PIGGY && (kind_q == K_DATA));
    pend_n = flush ? 4'd0 : (req_vec | (pend_q & ~clr));
  end

  always_comb begin
    state_n  = state_q;
    kind_n   = kind_q;
    len_n    = len_q;
    starve_n = starve_q;
    tmo_n    = '0;
    rereq_n  = rereq_q | own_req;
    abort_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rereq_n = 1'b0;
        if (win != K_NONE) begin
          state_n = S_ISSUE;
          kind_n  = win;
          len_n   = (win == K_DATA) ? data_len : 16'd0;
          if (win == K_DATA)
            starve_n = '0;
          else if (data_req && !starved)
            starve_n = starve_q + 1'b1;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          state_n = S_COMMIT;
        end else if (tmo_q == TMO_LAST) begin
          state_n = S_IDLE;
          abort_n = 1'b1;
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      S_COMMIT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (state_q != S_IDLE && state_n == S_IDLE) begin
      kind_n = K_NONE;
      len_n  = '0;
    end
    if (flush) begin
      state_n  = S_IDLE;
      kind_n   = K_NONE;
      len_n    = '0;
      starve_n = '0;
      tmo_n    = '0;
      rereq_n  = 1'b0;
      abort_n  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      len_q    <= '0;
      pend_q   <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
      rereq_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      kind_q   <= kind_n;
      len_q    <= len_n;
      pend_q   <= pend_n;
      starve_q <= starve_n;
      tmo_q    <= tmo_n;
      rereq_q  <= rereq_n;
      abort_q  <= abort_n;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign tx_start       = (state_q == S_ISSUE);
  assign tx_kind        = kind_q;
  assign tx_len         = len_q;
  assign tx_abort       = abort_q;
  assign data_ready     = commit && (kind_q == K_DATA);
  assign ip_id_data_new = commit && (kind_q == K_DATA);
  assign ip_id_link_new = commit && (kind_q != K_DATA) && (kind_q != K_NONE);
  assign seq_link_add   = (commit && (kind_q == K_SYN || kind_q == K_FIN))
                        ? 32'd1 : 32'd0;
  assign seq_data_add   = (commit && (kind_q == K_DATA))
                        ? {16'd0, len_q} : 32'd0;

endmodule

// File: doc/tcp_tx_arbiter.md
# tcp_tx_arbiter

- Single scheduler for the one TCP/IP frame builder.
- Inputs are transmit requests from:
  - the connection state machine: SYN-ACK, ACK-of-FIN, own FIN and pure ACK pulses;
  - the payload path: a data segment with a length.
- It picks one request at a time, starts the builder and waits for completion. After completion it issues the sequence-number advance and IP-identification increment that the state manager applies to its local counters.
- It sits between the state manager and the TX frame builder.

## Interface
- `MAX_WAIT`, default 16: number of consecutive non-data grants while data waits; after this many, DATA is promoted above ACK.
- `TX_TIMEOUT`, default 1024: cycles allowed in WAIT_DONE before the frame is aborted.

- `aclk` in 1: clock.
- `areset` in 1: reset, synchronous, active-high.
- `req_syn_ack` in 1: one-cycle pulse; send SYN-ACK.
- `req_fin_ack` in 1: one-cycle pulse; ACK the peer's FIN.
- `req_fin` in 1: one-cycle pulse; send own FIN.
- `req_ack` in 1: one-cycle pulse; send a pure ACK.
- `data_valid` in 1: level; a data segment is waiting.
- `data_len` in 16: payload bytes; stable while `data_valid` is high.
- `data_ready` out 1: one-cycle pulse; the data segment was sent and is consumed.
- `flush` in 1: drop everything (disconnect / state reset).
- `tx_start` out 1: one-cycle pulse to the builder.
- `tx_kind` out 3: frame kind, held from `tx_start` until commit or abort. 0 none, 1 SYN_ACK, 2 FIN_ACK, 3 FIN, 4 ACK, 5 DATA.
- `tx_len` out 16: payload length for DATA, else 0; held like `tx_kind`.
- `tx_done` in 1: one-cycle pulse from the builder; frame fully sent.
- `tx_abort` out 1: one-cycle pulse; in-flight frame abandoned (timeout or flush).
- `seq_link_add` out 32: sequence advance for control frames; nonzero only in the COMMIT cycle.
- `seq_data_add` out 32: sequence advance for data; nonzero only in the COMMIT cycle.
- `ip_id_link_new` out 1: one-cycle IP-identification increment for control/ACK frames.
- `ip_id_data_new` out 1: one-cycle IP-identification increment for data frames.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Pending flags.** Each `req_*` pulse sets its own pending bit. A repeat pulse while the bit is already set merges into it. DATA has no pending bit: it is the level `data_valid && data_len != 0`.
- **Priority.** SYN_ACK > FIN_ACK > FIN > ACK > DATA.
- **Starvation guard.** While DATA is requesting and loses, `starve_cnt` counts grants, saturating at `MAX_WAIT`. When `starve_cnt == MAX_WAIT`, DATA ranks above ACK but still below SYN_ACK, FIN_ACK and FIN. `starve_cnt` clears on every DATA grant.
- **FSM: IDLE → ISSUE → WAIT_DONE → COMMIT → IDLE.**
  - IDLE: if any request exists, latch the winner into `tx_kind`/`tx_len` and go to ISSUE.
  - ISSUE: `tx_start` = 1; go to WAIT_DONE.
  - WAIT_DONE: `tx_done` → COMMIT. Timeout counter reaching `TX_TIMEOUT-1` → `tx_abort`, IDLE; the pending bit is kept, so the frame is retried.
  - COMMIT: clear the granted pending bit and emit side effects, then go to IDLE. `tx_kind` returns to 0.
- **Commit side effects.**
  - SYN_ACK or FIN: `seq_link_add` = 1.
  - FIN_ACK or ACK: `seq_link_add` = 0.
  - DATA: `seq_data_add` = zero-extended latched `tx_len`, and `data_ready` pulses.
  - Every commit pulses exactly one of `ip_id_link_new` / `ip_id_data_new`.
- **Request arriving during flight.** A request for the kind currently in flight, arriving after ISSUE, re-sets that pending bit; the clear in COMMIT only removes the grant already served. If the set and the clear land in the same cycle, set wins.
- **Flush.** Clears all pending bits and `starve_cnt` and forces IDLE with no commit effects.
  - If asserted in ISSUE or WAIT_DONE, `tx_abort` pulses in the following cycle.
  - A request and `flush` in the same cycle: flush wins and the request is lost.
- **`tx_done` outside WAIT_DONE** is ignored.

## Timing
- **Reset values.** All outputs are 0; FSM in IDLE; pending bits, `starve_cnt` and the timeout counter are 0.
- **Request to start.** `req_*` high in cycle c → pending visible in c+1 → grant latched at the end of c+1 → `tx_start` in c+2. DATA with `data_valid` high in c gives `tx_start` in c+1.
- **Done to commit.** `tx_done` in cycle d → COMMIT outputs in d+1 → IDLE in d+2 → next `tx_start` no earlier than d+3.
- **Timeout.** The counter starts at 0 on entry to WAIT_DONE. The abort fires `TX_TIMEOUT` cycles after entry.
- **Input stability.** `data_len` must be stable from grant until `data_ready`. `tx_len` is a copy latched at grant, so later changes to `data_len` have no effect on the frame in flight.

## Configuration
- `TCP_TX_ARB_ACK_PIGGYBACK_EN` defined: a DATA commit also clears pending ACK, because the data segment carries the ACK.
- Not defined: a pending ACK survives a DATA commit and is sent as its own frame.

## Test plan
- **SYN-ACK basic.** `req_syn_ack` pulse at cycle 10, `tx_done` at 20 → `tx_start` at 12 with `tx_kind` = 1; at 21 `seq_link_add` = 1 and `ip_id_link_new` = 1; `busy` low at 22.
- **Simultaneous requests.** `req_ack` and `req_fin` in the same cycle, builder done after 5 cycles each → FIN (kind 3) sent first, then ACK (kind 4); two `ip_id_link_new` pulses in total.
- **Starvation guard.** `data_valid` held with `data_len` = 100; 17 `req_ack` pulses, each issued while the previous ACK is in flight; `MAX_WAIT` = 16 → DATA is granted after the 16th ACK; `seq_data_add` = 100 and `data_ready` pulse at commit.
- **Timeout retry.** `req_fin`, `tx_done` withheld; `TX_TIMEOUT` = 8 → `tx_abort` 8 cycles after entering WAIT_DONE, then `tx_start` again with kind 3; no `seq_link_add` on the abort.
- **Flush mid-flight.** `flush` in WAIT_DONE of a DATA frame → `tx_abort` next cycle, no `data_ready`, no `ip_id_*`, and `busy` goes to 0. A `tx_done` one cycle later is ignored.
- **Piggyback.** `req_ack` raised while a DATA frame is in flight → with the macro defined, no separate kind-4 frame; without it, a kind-4 frame follows.
